alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_core.sv | 107 ++++++++++
 rtl/alu_pipe.sv | 127 ++++++++++++
 tb/tb_alu_pipe.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared constants for the pipelined ALU: opcode encodings and the bit
// positions of the four status flags carried alongside every result.
// No ports (package).
// -----------------------------------------------------------------------------
package alu_pkg;

    // Width of the encodings below; the datapath may use a different
    // opcode width and size-casts these constants to match.
    localparam int OPC_W = 6;

    localparam logic [OPC_W-1:0] OP_ADD = 6'b100000;
    localparam logic [OPC_W-1:0] OP_SUB = 6'b100010;
    localparam logic [OPC_W-1:0] OP_AND = 6'b100100;
    localparam logic [OPC_W-1:0] OP_OR  = 6'b100101;
    localparam logic [OPC_W-1:0] OP_XOR = 6'b100110;
    localparam logic [OPC_W-1:0] OP_NOR = 6'b100111;
    localparam logic [OPC_W-1:0] OP_SRL = 6'b000010;
    localparam logic [OPC_W-1:0] OP_SRA = 6'b000011;

    // flags = {overflow, carry, negative, zero}
    localparam int NB_FLAGS   = 4;
    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_NEG   = 1;
    localparam int FLAG_CARRY = 2;
    localparam int FLAG_OVF   = 3;

endpackage : alu_pkg

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Purely combinational ALU evaluated between the operand stage and the
// result stage of alu_pipe.
//
// Ports:
//   a_i       operand A
//   b_i       operand B (also the unsigned shift amount for SRL/SRA)
//   opcode_i  operation select
//   result_o  computed result
//   flags_o   {overflow, carry, negative, zero}
//   err_o     1 when opcode_i is not a recognised operation
// -----------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
#(
    parameter int NB_OPERANDO = 8,
    parameter int NB_OPCODE   = 6
) (
    input  logic [NB_OPERANDO-1:0] a_i,
    input  logic [NB_OPERANDO-1:0] b_i,
    input  logic [NB_OPCODE-1:0]   opcode_i,
    output logic [NB_OPERANDO-1:0] result_o,
    output logic [NB_FLAGS-1:0]    flags_o,
    output logic                   err_o
);

    localparam int MSB = NB_OPERANDO - 1;

    localparam logic [NB_OPCODE-1:0] C_ADD = NB_OPCODE'(OP_ADD);
    localparam logic [NB_OPCODE-1:0] C_SUB = NB_OPCODE'(OP_SUB);
    localparam logic [NB_OPCODE-1:0] C_AND = NB_OPCODE'(OP_AND);
    localparam logic [NB_OPCODE-1:0] C_OR  = NB_OPCODE'(OP_OR);
    localparam logic [NB_OPCODE-1:0] C_XOR = NB_OPCODE'(OP_XOR);
    localparam logic [NB_OPCODE-1:0] C_NOR = NB_OPCODE'(OP_NOR);
    localparam logic [NB_OPCODE-1:0] C_SRL = NB_OPCODE'(OP_SRL);
    localparam logic [NB_OPCODE-1:0] C_SRA = NB_OPCODE'(OP_SRA);

    // Operand width expressed in operand-wide arithmetic; NB_OPERANDO always
    // fits because 2**NB_OPERANDO > NB_OPERANDO.
    localparam logic [NB_OPERANDO-1:0] SHIFT_LIMIT = NB_OPERANDO'(NB_OPERANDO);

    // One extra bit so the top bit is the carry-out (ADD) or the borrow (SUB).
    logic [NB_OPERANDO:0]   sum_w;
    logic [NB_OPERANDO:0]   diff_w;
    logic                   shift_big_w;
    logic [NB_OPERANDO-1:0] srl_w;
    logic [NB_OPERANDO-1:0] sra_w;

    logic [NB_OPERANDO-1:0] res_c;
    logic                   carry_c;
    logic                   ovf_c;
    logic                   err_c;

    assign sum_w  = {1'b0, a_i} + {1'b0, b_i};
    assign diff_w = {1'b0, a_i} - {1'b0, b_i};

    // The full shift amount is honoured: anything at or beyond the operand
    // width drains the value completely (zeros, or sign copies for SRA).
    assign shift_big_w = (b_i >= SHIFT_LIMIT);
    assign srl_w = shift_big_w ? '0 : (a_i >> b_i);
    assign sra_w = shift_big_w ? {NB_OPERANDO{a_i[MSB]}}
                               : NB_OPERANDO'($signed(a_i) >>> b_i);

    always_comb begin
        res_c   = '0;
        carry_c = 1'b0;
        ovf_c   = 1'b0;
        err_c   = 1'b0;
        case (opcode_i)
            C_ADD: begin
                res_c   = sum_w[MSB:0];
                carry_c = sum_w[NB_OPERANDO];
                // Same-sign operands producing a different-sign result.
                ovf_c   = (a_i[MSB] == b_i[MSB]) && (sum_w[MSB] != a_i[MSB]);
            end
            C_SUB: begin
                res_c   = diff_w[MSB:0];
                carry_c = diff_w[NB_OPERANDO];
                // Opposite-sign operands where the result sign leaves A's.
                ovf_c   = (a_i[MSB] != b_i[MSB]) && (diff_w[MSB] != a_i[MSB]);
            end
            C_AND: res_c = a_i & b_i;
            C_OR:  res_c = a_i | b_i;
            C_XOR: res_c = a_i ^ b_i;
            C_NOR: res_c = ~(a_i | b_i);
            C_SRL: res_c = srl_w;
            C_SRA: res_c = sra_w;
            default: begin
                // Result stays zero, so the zero flag alone ends up set.
                err_c = 1'b1;
            end
        endcase
    end

    always_comb begin
        flags_o             = '0;
        flags_o[FLAG_ZERO]  = (res_c == '0);
        flags_o[FLAG_NEG]   = res_c[MSB];
        flags_o[FLAG_CARRY] = carry_c;
        flags_o[FLAG_OVF]   = ovf_c;
    end

    assign result_o = res_c;
    assign err_o    = err_c;

endmodule : alu_core

// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe
// Two-stage pipelined ALU with valid/ready flow control on both sides.
// Stage 1 registers the operands and opcode; alu_core evaluates them and
// stage 2 registers result, flags and err together.
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-high reset
//   dato_a     operand A
//   dato_b     operand B / shift amount
//   opcode     operation select
//   in_valid   upstream offers an operation
//   in_ready   block accepts the offered operation this cycle
//   out        registered result
//   flags      registered {overflow, carry, negative, zero}
//   err        registered illegal-opcode indication
//   out_valid  out/flags/err hold a result
//   out_ready  downstream consumes the result this cycle
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_ready never depends on in_valid; out_valid never depends on
// out_ready. Once out_valid is high, out/flags/err hold steady until the
// result is consumed. Both stages advance together, so a consume and an
// accept in the same cycle keep streaming at one operation per cycle.
// -----------------------------------------------------------------------------
module alu_pipe
    import alu_pkg::*;
#(
    parameter int NB_OPERANDO = 8,
    parameter int NB_OPCODE   = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NB_OPERANDO-1:0] dato_a,
    input  logic [NB_OPERANDO-1:0] dato_b,
    input  logic [NB_OPCODE-1:0]   opcode,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [NB_OPERANDO-1:0] out,
    output logic [NB_FLAGS-1:0]    flags,
    output logic                   err,
    output logic                   out_valid,
    input  logic                   out_ready
);

    // Stage 1: operands
    logic                   s1_valid_q;
    logic [NB_OPERANDO-1:0] s1_a_q;
    logic [NB_OPERANDO-1:0] s1_b_q;
    logic [NB_OPCODE-1:0]   s1_op_q;

    // Stage 2: result
    logic                   out_valid_q;
    logic [NB_OPERANDO-1:0] out_q;
    logic [NB_FLAGS-1:0]    flags_q;
    logic                   err_q;

    // Combinational compute feeding stage 2
    logic [NB_OPERANDO-1:0] out_d;
    logic [NB_FLAGS-1:0]    flags_d;
    logic                   err_d;

    logic s2_load;
    logic s1_load;

    // Stage 2 can take a new value when it is empty or being drained;
    // stage 1 can when it is empty or is moving into stage 2.
    assign s2_load = !out_valid_q || out_ready;
    assign s1_load = !s1_valid_q || s2_load;

    // Held low while reset is asserted so nothing is offered acceptance
    // from a pipeline that is being cleared.
    assign in_ready = !reset && s1_load;

    alu_core #(
        .NB_OPERANDO (NB_OPERANDO),
        .NB_OPCODE   (NB_OPCODE)
    ) u_core (
        .a_i      (s1_a_q),
        .b_i      (s1_b_q),
        .opcode_i (s1_op_q),
        .result_o (out_d),
        .flags_o  (flags_d),
        .err_o    (err_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= '0;
        end else if (s1_load) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_a_q  <= dato_a;
                s1_b_q  <= dato_b;
                s1_op_q <= opcode;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            flags_q     <= '0;
            err_q       <= 1'b0;
        end else if (s2_load) begin
            out_valid_q <= s1_valid_q;
            // Data registers only move with a real operation, so a bubble
            // leaves the last result visible (but not valid).
            if (s1_valid_q) begin
                out_q   <= out_d;
                flags_q <= flags_d;
                err_q   <= err_d;
            end
        end
    end

    assign out       = out_q;
    assign flags     = flags_q;
    assign err       = err_q;
    assign out_valid = out_valid_q;

endmodule : alu_pipe

// File: tb/tb_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe
// Directed self-checking bench for alu_pipe (NB_OPERANDO = 8). Inputs are
// driven and outputs sampled on the falling edge of the clock.
// -----------------------------------------------------------------------------
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int NBO = 8;
    localparam int NBC = 6;

    logic           clk;
    logic           reset;
    logic [NBO-1:0] dato_a;
    logic [NBO-1:0] dato_b;
    logic [NBC-1:0] opcode;
    logic           in_valid;
    logic           in_ready;
    logic [NBO-1:0] out;
    logic [3:0]     flags;
    logic           err;
    logic           out_valid;
    logic           out_ready;

    int checks;
    int errors;

    // Expected {err, flags[3:0], out[7:0]} in acceptance order
    logic [12:0] exp_q[$];

    alu_pipe #(
        .NB_OPERANDO (NBO),
        .NB_OPCODE   (NBC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .dato_a    (dato_a),
        .dato_b    (dato_b),
        .opcode    (opcode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .flags     (flags),
        .err       (err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic drive_op(input logic [7:0] a, input logic [7:0] b,
                            input logic [5:0] op);
        in_valid = 1'b1;
        dato_a   = a;
        dato_b   = b;
        opcode   = op;
    endtask

    // Offers one op at a falling edge with out_ready=1 and reports in_ready at
    // offer time, out_valid after the accept edge, and the outputs after the
    // following edge.
    task automatic send_and_capture(input logic [7:0] a, input logic [7:0] b,
                                    input logic [5:0] op,
                                    output logic rdy, output logic v1,
                                    output logic v2, output logic [7:0] r,
                                    output logic [3:0] f, output logic e);
        @(negedge clk);
        out_ready = 1'b1;
        drive_op(a, b, op);
        rdy = in_ready;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        v1 = out_valid;
        @(posedge clk);
        @(negedge clk);
        v2 = out_valid;
        r  = out;
        f  = flags;
        e  = err;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        #12;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out !== 8'h00 ||
            flags !== 4'h0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: out_valid=%b in_ready=%b out=%h flags=%b err=%b, need 0 0 00 0000 0",
                     out_valid, in_ready, out, flags, err);
        end
        // Release and offer immediately: the next rising edge must accept.
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        drive_op(8'h00, 8'h00, OP_OR);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL first_accept_ready: in_ready=%b need 1", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_accept_lat1: out_valid=%b need 0", out_valid);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out !== 8'h00 || flags !== 4'b0001 || err !== 1'b0) begin
            errors++;
            $display("FAIL first_accept_result: v=%b out=%h flags=%b err=%b need 1 00 0001 0",
                     out_valid, out, flags, err);
        end
    endtask

    // Directed single-op vectors: {a, b, op, exp_out, exp_flags, exp_err}
    task automatic test_arith_logic_shift;
        logic [7:0] ta [14];
        logic [7:0] tb [14];
        logic [5:0] to [14];
        logic [7:0] tr [14];
        logic [3:0] tf [14];
        logic       te [14];
        logic rdy, v1, v2, e;
        logic [7:0] r;
        logic [3:0] f;
        ta = '{8'h7F, 8'hFF, 8'h12, 8'h00, 8'h80, 8'h05, 8'hF0,
               8'h0F, 8'hAA, 8'h00, 8'h80, 8'h80, 8'h80, 8'h80};
        tb = '{8'h01, 8'h01, 8'h34, 8'h01, 8'h01, 8'h05, 8'h3C,
               8'h80, 8'hAA, 8'h00, 8'h03, 8'h09, 8'h09, 8'h03};
        to = '{OP_ADD, OP_ADD, OP_ADD, OP_SUB, OP_SUB, OP_SUB, OP_AND,
               OP_OR,  OP_XOR, OP_NOR, OP_SRA, OP_SRA, OP_SRL, OP_SRL};
        tr = '{8'h80, 8'h00, 8'h46, 8'hFF, 8'h7F, 8'h00, 8'h30,
               8'h8F, 8'h00, 8'hFF, 8'hF0, 8'hFF, 8'h00, 8'h10};
        tf = '{4'b1010, 4'b0101, 4'b0000, 4'b0110, 4'b1000, 4'b0001, 4'b0000,
               4'b0010, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0000};
        te = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 14; i++) begin
            send_and_capture(ta[i], tb[i], to[i], rdy, v1, v2, r, f, e);
            checks++;
            if (rdy !== 1'b1 || v1 !== 1'b0 || v2 !== 1'b1) begin
                errors++;
                $display("FAIL vec%0d_timing: in_ready=%b v_after1=%b v_after2=%b need 1 0 1",
                         i, rdy, v1, v2);
            end
            checks++;
            if (r !== tr[i] || f !== tf[i] || e !== te[i]) begin
                errors++;
                $display("FAIL vec%0d_result: out=%h flags=%b err=%b need %h %b %b",
                         i, r, f, e, tr[i], tf[i], te[i]);
            end
        end
    endtask

    task automatic test_illegal;
        logic rdy, v1, v2, e;
        logic [7:0] r;
        logic [3:0] f;
        send_and_capture(8'h55, 8'h0F, 6'b111111, rdy, v1, v2, r, f, e);
        checks++;
        if (v2 !== 1'b1 || r !== 8'h00 || f !== 4'b0001 || e !== 1'b1) begin
            errors++;
            $display("FAIL illegal_op: v=%b out=%h flags=%b err=%b need 1 00 0001 1",
                     v2, r, f, e);
        end
        send_and_capture(8'h01, 8'h01, OP_ADD, rdy, v1, v2, r, f, e);
        checks++;
        if (v2 !== 1'b1 || r !== 8'h02 || f !== 4'b0000 || e !== 1'b0) begin
            errors++;
            $display("FAIL after_illegal: v=%b out=%h flags=%b err=%b need 1 02 0000 0",
                     v2, r, f, e);
        end
    endtask

    task automatic test_backpressure;
        logic [7:0]  ta [3];
        logic [7:0]  tb [3];
        logic [5:0]  to [3];
        logic [12:0] tx [3];
        logic [12:0] got;
        logic [12:0] head;
        int k;
        int rcv;
        int budget;
        ta = '{8'h01, 8'h10, 8'hFF};
        tb = '{8'h02, 8'h20, 8'h0F};
        to = '{OP_ADD, OP_SUB, OP_XOR};
        tx = '{13'h0003, 13'h06F0, 13'h02F0};
        k = 0;
        rcv = 0;
        exp_q.delete();
        @(negedge clk);
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            drive_op(ta[k], tb[k], to[k]);
            if (in_ready === 1'b1) begin
                exp_q.push_back(tx[k]);
                k++;
            end
            @(posedge clk);
        end
        @(negedge clk);
        checks++;
        if (k !== 2 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_two_accepted: accepted=%0d in_ready=%b out_valid=%b need 2 0 1",
                     k, in_ready, out_valid);
        end
        head = tx[0];
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            got = {err, flags, out};
            checks++;
            if (got !== head || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_stable%0d: got=%h v=%b in_ready=%b need %h 1 0",
                         c, got, out_valid, in_ready, head);
            end
        end
        // Drain while the third op is still being offered.
        out_ready = 1'b1;
        budget = 20;
        while (rcv < 3 && budget > 0) begin
            if (out_valid === 1'b1) begin
                got = {err, flags, out};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bp_extra: unexpected result %h", got);
                end else begin
                    head = exp_q.pop_front();
                    if (got !== head) begin
                        errors++;
                        $display("FAIL bp_order%0d: got=%h need %h", rcv, got, head);
                    end
                end
                rcv++;
            end
            if (k < 3) begin
                drive_op(ta[k], tb[k], to[k]);
                if (in_ready === 1'b1) begin
                    exp_q.push_back(tx[k]);
                    k++;
                end
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            budget--;
        end
        in_valid = 1'b0;
        checks++;
        if (rcv !== 3 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_drain: received=%0d left=%0d need 3 0", rcv, exp_q.size());
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0]  ta [6];
        logic [7:0]  tb [6];
        logic [5:0]  to [6];
        logic [12:0] tx [6];
        logic [12:0] got;
        logic [12:0] head;
        int k;
        int rcv;
        int stalls;
        int budget;
        ta = '{8'hF0, 8'h0F, 8'h00, 8'hFF, 8'hFF, 8'h40};
        tb = '{8'h3C, 8'h80, 8'h00, 8'h01, 8'h07, 8'h08};
        to = '{OP_AND, OP_OR, OP_NOR, OP_ADD, OP_SRL, OP_SRA};
        tx = '{13'h0030, 13'h028F, 13'h02FF, 13'h0500, 13'h0001, 13'h0100};
        k = 0;
        rcv = 0;
        stalls = 0;
        exp_q.delete();
        @(negedge clk);
        out_ready = 1'b1;
        budget = 12;
        while (rcv < 6 && budget > 0) begin
            if (out_valid === 1'b1) begin
                got = {err, flags, out};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra: unexpected result %h", got);
                end else begin
                    head = exp_q.pop_front();
                    if (got !== head) begin
                        errors++;
                        $display("FAIL b2b_order%0d: got=%h need %h", rcv, got, head);
                    end
                end
                rcv++;
            end
            if (k < 6) begin
                drive_op(ta[k], tb[k], to[k]);
                if (in_ready === 1'b1) begin
                    exp_q.push_back(tx[k]);
                    k++;
                end else begin
                    stalls++;
                end
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            budget--;
        end
        in_valid = 1'b0;
        checks++;
        if (stalls !== 0 || rcv !== 6 || budget < 4) begin
            errors++;
            $display("FAIL b2b_throughput: stalls=%0d received=%0d cycles_used=%0d need 0 6 8",
                     stalls, rcv, 12 - budget);
        end
    endtask

    task automatic test_reset_midflight;
        int stale;
        logic rdy, v1, v2, e;
        logic [7:0] r;
        logic [3:0] f;
        @(negedge clk);
        out_ready = 1'b0;
        drive_op(8'h01, 8'h01, OP_ADD);
        @(posedge clk);
        @(negedge clk);
        drive_op(8'h03, 8'h01, OP_SUB);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_precond: out_valid=%b in_ready=%b need 1 0", out_valid, in_ready);
        end
        // Assert reset between clock edges; outputs must clear at once.
        #1 reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out !== 8'h00 ||
            flags !== 4'h0 || err !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: out_valid=%b in_ready=%b out=%h flags=%b err=%b need 0 0 00 0000 0",
                     out_valid, in_ready, out, flags, err);
        end
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid !== 1'b0) stale++;
        end
        checks++;
        if (stale !== 0) begin
            errors++;
            $display("FAIL rst_no_stale: stale_cycles=%0d need 0", stale);
        end
        send_and_capture(8'h20, 8'h22, OP_ADD, rdy, v1, v2, r, f, e);
        checks++;
        if (v2 !== 1'b1 || r !== 8'h42 || f !== 4'b0000 || e !== 1'b0) begin
            errors++;
            $display("FAIL rst_recover: v=%b out=%h flags=%b err=%b need 1 42 0000 0",
                     v2, r, f, e);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        dato_a    = '0;
        dato_b    = '0;
        opcode    = '0;
        out_ready = 1'b0;

        test_reset();
        test_arith_logic_shift();
        test_illegal();
        test_backpressure();
        test_back_to_back();
        test_reset_midflight();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_alu_pipe
